jk_input_conditioner: RTL and testbench

JK_INPUT_CONDITIONER -- requirements
Module: jk_input_conditioner

---
 rtl/jk_lab_pkg.sv | 27 ++
 rtl/debounce_channel.sv | 96 +++++++++
 rtl/jk_input_conditioner.sv | 90 +++++++++
 tb/tb_jk_input_conditioner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/jk_lab_pkg.sv
// Shared definitions for the JK flip-flop lab input conditioner:
// debounce channel state encoding and default timing constants.
package jk_lab_pkg;

  // 20 ms of stable input at the 100 MHz board clock.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 2_000_000;

  // Depth of the metastability synchronizer on each raw input.
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  // Width of the press counter shown on the LEDs.
  localparam int unsigned STEP_COUNT_W = 8;

  // Debounce FSM states. The clean level is 1 in S_HIGH and S_FALL_CHK.
  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } chan_state_t;

  // Clean output level implied by a channel state.
  function automatic logic level_of(input chan_state_t state);
    return (state == S_HIGH) || (state == S_FALL_CHK);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: a shift-register synchronizer followed by a
// four-state stability checker. The channel reports the clean level it will
// hold after the coming edge; the parent registers that value, so the
// registered level changes on the same edge the FSM commits a transition.
module debounce_channel
  import jk_lab_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level_next
);

  // The counter only has to reach DEBOUNCE_CYCLES-1, so it never wraps.
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;
  chan_state_t            r_state;
  chan_state_t            w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;

  // Synchronizer: shift the raw input through SYNC_STAGES flops.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, as real hardware does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  // State and stability-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and counter logic. A check state either counts one more
  // matching sample, commits after the last one, or aborts on a mismatch.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; without them
    // the unassigned paths would infer latches.
    w_state_next = r_state;
    w_cnt_next   = '0;
    unique case (r_state)
      S_LOW: begin
        if (w_synced) begin
          w_state_next = S_RISE_CHK;
        end
      end
      S_RISE_CHK: begin
        if (!w_synced) begin
          w_state_next = S_LOW;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_HIGH;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!w_synced) begin
          w_state_next = S_FALL_CHK;
        end
      end
      S_FALL_CHK: begin
        if (w_synced) begin
          w_state_next = S_HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = S_LOW;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_LOW;
      end
    endcase
  end

  assign o_level_next = level_of(w_state_next);

endmodule

// File: rtl/jk_input_conditioner.sv
// Conditions the lab board's J/K slide switches and step button for a
// downstream master-slave JK flip-flop: three independent debounce
// channels, registered clean levels, a press strobe and a press counter.
module jk_input_conditioner
  import jk_lab_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sw_j,
  input  logic                    sw_k,
  input  logic                    btn_step,
  output logic                    J,
  output logic                    K,
  output logic                    step_level,
  output logic                    step_pulse,
  output logic [STEP_COUNT_W-1:0] step_count
);

  logic                    w_j_next;
  logic                    w_k_next;
  logic                    w_btn_next;
  logic                    w_step_rise;
  logic                    r_j;
  logic                    r_k;
  logic                    r_step_level;
  logic                    r_step_pulse;
  logic [STEP_COUNT_W-1:0] r_step_count;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_j_chan (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_raw        (sw_j),
    .o_level_next (w_j_next)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_k_chan (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_raw        (sw_k),
    .o_level_next (w_k_next)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_btn_chan (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_raw        (btn_step),
    .o_level_next (w_btn_next)
  );

  // A press is the button level about to go 0 -> 1; release is ignored.
  assign w_step_rise = w_btn_next & ~r_step_level;

  // Clean levels, press strobe and press counter all update on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_j          <= 1'b0;
      r_k          <= 1'b0;
      r_step_level <= 1'b0;
      r_step_pulse <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_j          <= w_j_next;
      r_k          <= w_k_next;
      r_step_level <= w_btn_next;
      r_step_pulse <= w_step_rise;
      if (w_step_rise) begin
        r_step_count <= r_step_count + 1'b1;
      end
    end
  end

  assign J          = r_j;
  assign K          = r_k;
  assign step_level = r_step_level;
  assign step_pulse = r_step_pulse;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_jk_input_conditioner.sv
// Bench for jk_input_conditioner with a short debounce window. A reference
// model states the debounce rule directly: each raw sample reaches the
// checker two edges later, and the clean level takes a new value once that
// value has been seen on DEBOUNCE_CYCLES+1 consecutive edges.
module tb_jk_input_conditioner;
  import jk_lab_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_j = 1'b0;
  logic       sw_k = 1'b0;
  logic       btn_step = 1'b0;
  logic       J;
  logic       K;
  logic       step_level;
  logic       step_pulse;
  logic [7:0] step_count;

  int n_tests = 0;
  int n_fail = 0;
  int n_pulses_seen = 0;

  // Reference model: raw-sample delay line, run length of the disagreeing
  // value, clean levels (0=J, 1=K, 2=button), strobe and press count.
  bit m_dly1 [3];
  bit m_dly2 [3];
  int m_run  [3];
  bit m_out  [3];
  bit m_pulse;
  int m_count;

  jk_input_conditioner #(
    .DEBOUNCE_CYCLES (N),
    .SYNC_STAGES     (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_j       (sw_j),
    .sw_k       (sw_k),
    .btn_step   (btn_step),
    .J          (J),
    .K          (K),
    .step_level (step_level),
    .step_pulse (step_pulse),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int ch = 0; ch < 3; ch++) begin
      m_dly1[ch] = 1'b0;
      m_dly2[ch] = 1'b0;
      m_run[ch]  = 0;
      m_out[ch]  = 1'b0;
    end
    m_pulse = 1'b0;
    m_count = 0;
  endtask

  task automatic model_edge(input bit [2:0] raw);
    bit seen;
    bit prev_btn;
    if (!rst_n) begin
      model_clear();
    end else begin
      prev_btn = m_out[2];
      for (int ch = 0; ch < 3; ch++) begin
        seen       = m_dly2[ch];
        m_dly2[ch] = m_dly1[ch];
        m_dly1[ch] = raw[ch];
        if (seen != m_out[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == N + 1) begin
            m_out[ch] = seen;
            m_run[ch] = 0;
          end
        end else begin
          m_run[ch] = 0;
        end
      end
      m_pulse = m_out[2] && !prev_btn;
      if (m_pulse) m_count = (m_count + 1) % 256;
    end
  endtask

  task automatic compare_all();
    check("J", 8'(J), 8'(m_out[0]));
    check("K", 8'(K), 8'(m_out[1]));
    check("step_level", 8'(step_level), 8'(m_out[2]));
    check("step_pulse", 8'(step_pulse), 8'(m_pulse));
    check("step_count", step_count, 8'(m_count));
    if (step_pulse === 1'b1) n_pulses_seen++;
  endtask

  // Drive inputs at the falling edge, model the rising edge, check at the
  // next falling edge. raw = {btn_step, sw_k, sw_j}.
  task automatic cycle(input bit [2:0] raw);
    sw_j     = raw[0];
    sw_k     = raw[1];
    btn_step = raw[2];
    @(posedge clk);
    model_edge(raw);
    @(negedge clk);
    compare_all();
  endtask

  // Assert reset for two cycles while holding the given raw inputs.
  task automatic do_reset(input bit [2:0] raw);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_J", 8'(J), 8'd0);
    check("rst_K", 8'(K), 8'd0);
    check("rst_step_level", 8'(step_level), 8'd0);
    check("rst_step_pulse", 8'(step_pulse), 8'd0);
    check("rst_step_count", step_count, 8'd0);
    @(negedge clk);
    cycle(raw);
    cycle(raw);
    rst_n = 1'b1;
  endtask

  initial begin
    int         run_left [3];
    bit [2:0]   cur;

    model_clear();
    @(negedge clk);

    // Reset release with idle inputs.
    do_reset(3'b000);
    for (int i = 0; i < 20; i++) cycle(3'b000);
    check("idle_J", 8'(J), 8'd0);
    check("idle_step_count", step_count, 8'd0);

    // sw_j rises and holds: J must change exactly at edge N+2.
    for (int i = 0; i <= N + 2; i++) begin
      cycle(3'b001);
      check("j_rise_J", 8'(J), (i == N + 2) ? 8'd1 : 8'd0);
      check("j_rise_K", 8'(K), 8'd0);
    end
    for (int i = 0; i < 8; i++) cycle(3'b000);
    check("j_fall_J", 8'(J), 8'd0);

    // Button bounce 1,0,1,0 then held: one strobe, count 1.
    n_pulses_seen = 0;
    cycle(3'b100);
    cycle(3'b000);
    cycle(3'b100);
    cycle(3'b000);
    for (int i = 0; i < 10; i++) cycle(3'b100);
    check("bounce_pulses", 8'(n_pulses_seen), 8'd1);
    check("bounce_count", step_count, 8'd1);
    check("bounce_level", 8'(step_level), 8'd1);
    for (int i = 0; i < 10; i++) cycle(3'b000);
    check("release_pulses", 8'(n_pulses_seen), 8'd1);
    check("release_count", step_count, 8'd1);

    // Reset two cycles into the rise check on sw_k aborts it.
    do_reset(3'b000);
    for (int i = 0; i < 5; i++) cycle(3'b010);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("abort_K", 8'(K), 8'd0);
    check("abort_state", 8'(dut.u_k_chan.r_state), 8'(S_LOW));
    @(negedge clk);
    cycle(3'b010);
    cycle(3'b010);
    rst_n = 1'b1;
    for (int i = 0; i <= N + 2; i++) begin
      cycle(3'b010);
      check("post_rst_K", 8'(K), (i == N + 2) ? 8'd1 : 8'd0);
    end

    // All three inputs rise on the same edge.
    do_reset(3'b000);
    for (int i = 0; i <= N + 2; i++) begin
      cycle(3'b111);
      check("par_J", 8'(J), (i == N + 2) ? 8'd1 : 8'd0);
      check("par_K", 8'(K), (i == N + 2) ? 8'd1 : 8'd0);
      check("par_level", 8'(step_level), (i == N + 2) ? 8'd1 : 8'd0);
      check("par_pulse", 8'(step_pulse), (i == N + 2) ? 8'd1 : 8'd0);
    end
    check("par_count", step_count, 8'd1);

    // 256 clean presses wrap the counter back to zero.
    do_reset(3'b000);
    n_pulses_seen = 0;
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < N + 3; i++) cycle(3'b100);
      for (int i = 0; i < N + 3; i++) cycle(3'b000);
    end
    check("wrap_pulses", 8'(n_pulses_seen >> 8), 8'd1);
    check("wrap_pulses_lo", 8'(n_pulses_seen), 8'd0);
    check("wrap_count", step_count, 8'd0);

    // Random runs of 1..8 cycles per input: mixes bounces and stable holds.
    do_reset(3'b000);
    cur = 3'b000;
    for (int ch = 0; ch < 3; ch++) run_left[ch] = 0;
    for (int i = 0; i < 800; i++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (run_left[ch] == 0) begin
          cur[ch]      = ~cur[ch];
          run_left[ch] = int'($urandom_range(1, 8));
        end
        run_left[ch]--;
      end
      cycle(cur);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
